// File: rtl/patch_read_responder.sv
// Bus return-path responder: answers reads that hit the patch table locally and forwards everything else downstream.
// A patched read acks one cycle after it is accepted. A forwarded cycle acks one cycle after mi_ack_i.
module patch_read_responder #(
  parameter int          AW      = 16,
  parameter int          DW      = 32,
  parameter int          NPATCH  = 4,
  parameter int          IW      = $clog2(NPATCH),
  parameter logic [15:0] HIT_MAX = 16'hFFFF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          si_cyc_i,
  input  logic          si_stb_i,
  input  logic          si_we_i,
  input  logic [AW-1:0] si_addr_i,
  input  logic [DW-1:0] si_data_i,
  output logic [DW-1:0] si_data_o,
  output logic          si_ack_o,
  output logic          mi_cyc_o,
  output logic          mi_stb_o,
  output logic          mi_we_o,
  output logic [AW-1:0] mi_addr_o,
  output logic [DW-1:0] mi_data_o,
  input  logic [DW-1:0] mi_data_i,
  input  logic          mi_ack_i,
  input  logic          ctl_wr_i,
  input  logic [IW-1:0] ctl_idx_i,
  input  logic [AW-1:0] ctl_pat_addr_i,
  input  logic [DW-1:0] ctl_pat_data_i,
  input  logic          ctl_en_i,
  output logic [15:0]   hit_count_o
);

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       tab_addr_q [NPATCH];
  logic [DW-1:0]       tab_data_q [NPATCH];
  logic [NPATCH-1:0]   tab_vld_q;
  logic [DW-1:0]       si_data_q, si_data_d;
  logic                mi_cyc_q, mi_cyc_d;
  logic                mi_stb_q, mi_stb_d;
  logic                mi_we_q, mi_we_d;
  logic [AW-1:0]       mi_addr_q, mi_addr_d;
  logic [DW-1:0]       mi_data_q, mi_data_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic                drop_q, drop_d;
  logic                hit;
  logic [DW-1:0]       hit_data;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = NPATCH - 1; i >= 0; i--) begin
      if (tab_vld_q[i] && (tab_addr_q[i] == si_addr_i)) begin
        hit      = 1'b1;
        hit_data = tab_data_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NPATCH; i++) begin
        tab_addr_q[i] <= '0;
        tab_data_q[i] <= '0;
      end
      tab_vld_q <= '0;
    end else if (ctl_wr_i) begin
      tab_addr_q[ctl_idx_i] <= ctl_pat_addr_i;
      tab_data_q[ctl_idx_i] <= ctl_pat_data_i;
      tab_vld_q[ctl_idx_i]  <= ctl_en_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    si_data_d = si_data_q;
    mi_cyc_d  = mi_cyc_q;
    mi_stb_d  = mi_stb_q;
    mi_we_d   = mi_we_q;
    mi_addr_d = mi_addr_q;
    mi_data_d = mi_data_q;
    hit_cnt_d = hit_cnt_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: begin
        if (si_cyc_i && si_stb_i) begin
          if (!si_we_i && hit) begin
            si_data_d = hit_data;
            if (hit_cnt_q != HIT_MAX) hit_cnt_d = hit_cnt_q + 16'd1;
            state_d   = RESP;
          end else begin
            mi_cyc_d  = 1'b1;
            mi_stb_d  = 1'b1;
            mi_we_d   = si_we_i;
            mi_addr_d = si_addr_i;
            mi_data_d = si_data_i;
            drop_d    = 1'b0;
            state_d   = FWD;
          end
        end
      end
      FWD: begin
        // An upstream abandon is remembered so the eventual ack is swallowed.
        if (!si_cyc_i) drop_d = 1'b1;
        if (mi_ack_i) begin
          mi_cyc_d = 1'b0;
          mi_stb_d = 1'b0;
          if (drop_q || !si_cyc_i) begin
            state_d = IDLE;
          end else begin
            if (!mi_we_q) si_data_d = mi_data_i;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      si_data_q <= '0;
      mi_cyc_q  <= 1'b0;
      mi_stb_q  <= 1'b0;
      mi_we_q   <= 1'b0;
      mi_addr_q <= '0;
      mi_data_q <= '0;
      hit_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      si_data_q <= si_data_d;
      mi_cyc_q  <= mi_cyc_d;
      mi_stb_q  <= mi_stb_d;
      mi_we_q   <= mi_we_d;
      mi_addr_q <= mi_addr_d;
      mi_data_q <= mi_data_d;
      hit_cnt_q <= hit_cnt_d;
      drop_q    <= drop_d;
    end
  end

  assign si_ack_o    = (state_q == RESP);
  assign si_data_o   = si_data_q;
  assign mi_cyc_o    = mi_cyc_q;
  assign mi_stb_o    = mi_stb_q;
  assign mi_we_o     = mi_we_q;
  assign mi_addr_o   = mi_addr_q;
  assign mi_data_o   = mi_data_q;
  assign hit_count_o = hit_cnt_q;

endmodule

// File: tb/tb_patch_read_responder.sv
// Randomized bench for patch_read_responder against a table-lookup reference model.
module tb_patch_read_responder;
  localparam logic [15:0] TB_HIT_MAX = 16'd300;

  logic        clk = 1'b0;
  logic        rst;
  logic        si_cyc, si_stb, si_we;
  logic [15:0] si_addr;
  logic [31:0] si_wdata, si_rdata;
  logic        si_ack;
  logic        mi_cyc, mi_stb, mi_we;
  logic [15:0] mi_addr;
  logic [31:0] mi_wdata, mi_rdata;
  logic        mi_ack;
  logic        ctl_wr, ctl_en;
  logic [1:0]  ctl_idx;
  logic [15:0] ctl_addr;
  logic [31:0] ctl_data;
  logic [15:0] hit_count;

  patch_read_responder #(.AW(16), .DW(32), .NPATCH(4), .HIT_MAX(TB_HIT_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .si_cyc_i(si_cyc), .si_stb_i(si_stb), .si_we_i(si_we),
    .si_addr_i(si_addr), .si_data_i(si_wdata), .si_data_o(si_rdata), .si_ack_o(si_ack),
    .mi_cyc_o(mi_cyc), .mi_stb_o(mi_stb), .mi_we_o(mi_we),
    .mi_addr_o(mi_addr), .mi_data_o(mi_wdata), .mi_data_i(mi_rdata), .mi_ack_i(mi_ack),
    .ctl_wr_i(ctl_wr), .ctl_idx_i(ctl_idx), .ctl_pat_addr_i(ctl_addr),
    .ctl_pat_data_i(ctl_data), .ctl_en_i(ctl_en), .hit_count_o(hit_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the patch table as plain arrays plus the expected read-data register.
  logic [15:0] m_addr [4];
  logic [31:0] m_data [4];
  bit          m_vld  [4];
  int          m_hits;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0; m_data[i] = '0; m_vld[i] = 1'b0;
    end
    m_hits  = 0;
    m_rdata = '0;
  endfunction

  function automatic void model_lookup(input logic [15:0] a, output bit h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    for (int i = 0; i < 4; i++)
      if (!h && m_vld[i] && m_addr[i] == a) begin
        h = 1'b1;
        d = m_data[i];
      end
  endfunction

  function automatic void model_ctl();
    m_addr[ctl_idx] = ctl_addr;
    m_data[ctl_idx] = ctl_data;
    m_vld[ctl_idx]  = ctl_en;
  endfunction

  task automatic ctl_write(input logic [1:0] idx, input logic [15:0] a, input logic [31:0] d,
                           input logic en);
    ctl_wr = 1'b1; ctl_idx = idx; ctl_addr = a; ctl_data = d; ctl_en = en;
    @(posedge clk); #1;
    ctl_wr = 1'b0;
    model_ctl();
  endtask

  // One upstream transaction; with_ctl also fires the preloaded ctl_* write on the accept edge.
  task automatic bus_xfer(input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd, input bit with_ctl);
    bit          h;
    logic [31:0] pd;
    model_lookup(a, h, pd);
    si_cyc = 1'b1; si_stb = 1'b1; si_we = we; si_addr = a; si_wdata = wd;
    if (with_ctl) ctl_wr = 1'b1;
    @(posedge clk); #1;
    si_stb = 1'b0;
    if (with_ctl) begin
      ctl_wr = 1'b0;
      model_ctl();
    end
    if (!we && h) begin
      m_hits  = (m_hits >= int'(TB_HIT_MAX)) ? int'(TB_HIT_MAX) : m_hits + 1;
      m_rdata = pd;
      check("patch_ack", {31'b0, si_ack}, 32'd1);
      check("patch_no_stb", {31'b0, mi_stb}, 32'd0);
      check("patch_data", si_rdata, m_rdata);
      check("patch_hits", {16'b0, hit_count}, m_hits);
      si_cyc = 1'b0;
      @(posedge clk); #1;
      check("patch_ack_pulse", {31'b0, si_ack}, 32'd0);
    end else begin
      check("fwd_stb", {30'b0, mi_cyc, mi_stb}, 32'd3);
      check("fwd_addr", {16'b0, mi_addr}, {16'b0, a});
      check("fwd_we", {31'b0, mi_we}, {31'b0, we});
      if (we) check("fwd_wdata", mi_wdata, wd);
      check("fwd_early_ack", {31'b0, si_ack}, 32'd0);
      for (int w = 0; w < waits; w++) begin
        @(posedge clk); #1;
        check("fwd_hold", {15'b0, mi_stb, mi_addr}, {15'b0, 1'b1, a});
      end
      mi_ack = 1'b1; mi_rdata = rd;
      @(posedge clk); #1;
      mi_ack = 1'b0; mi_rdata = $urandom;
      if (!we) m_rdata = rd;
      check("fwd_ack", {31'b0, si_ack}, 32'd1);
      check("fwd_drop_stb", {30'b0, mi_cyc, mi_stb}, 32'd0);
      check("fwd_data", si_rdata, m_rdata);
      check("fwd_hits", {16'b0, hit_count}, m_hits);
      si_cyc = 1'b0;
      @(posedge clk); #1;
      check("fwd_ack_pulse", {31'b0, si_ack}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] pool [5];
    logic [15:0] ra;
    rst = 1'b1; si_cyc = 0; si_stb = 0; si_we = 0; si_addr = '0; si_wdata = '0;
    mi_ack = 0; mi_rdata = '0; ctl_wr = 0; ctl_idx = '0; ctl_addr = '0; ctl_data = '0; ctl_en = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outs", {si_ack, mi_cyc, mi_stb, mi_we, 28'b0}, 32'd0);
    check("rst_data", si_rdata | mi_wdata | {16'b0, mi_addr}, 32'd0);
    check("rst_hits", {16'b0, hit_count}, 32'd0);

    // Directed: patch hit, forwarded read, write to patched address.
    ctl_write(2'd1, 16'h0040, 32'hDEADBEEF, 1'b1);
    bus_xfer(1'b0, 16'h0040, '0, 0, '0, 1'b0);
    bus_xfer(1'b0, 16'h0044, '0, 2, 32'h12345678, 1'b0);
    bus_xfer(1'b1, 16'h0040, 32'h55, 1, '0, 1'b0);
    bus_xfer(1'b0, 16'h0040, '0, 0, '0, 1'b0);
    bus_xfer(1'b0, 16'h0048, '0, 0, 32'hA5A5A5A5, 1'b0);

    // Priority then disable.
    ctl_write(2'd0, 16'h0080, 32'h1, 1'b1);
    ctl_write(2'd2, 16'h0080, 32'h2, 1'b1);
    bus_xfer(1'b0, 16'h0080, '0, 0, '0, 1'b0);
    check("prio_low_idx", si_rdata, 32'h1);
    ctl_write(2'd0, 16'h0080, 32'h1, 1'b0);
    bus_xfer(1'b0, 16'h0080, '0, 0, '0, 1'b0);
    check("disable_idx0", si_rdata, 32'h2);

    // Table write in the accept cycle: lookup sees old contents.
    ctl_idx = 2'd3; ctl_addr = 16'h00C0; ctl_data = 32'hC0C0C0C0; ctl_en = 1'b1;
    bus_xfer(1'b0, 16'h00C0, '0, 1, 32'h0BADF00D, 1'b1);
    check("same_cycle_fwd", si_rdata, 32'h0BADF00D);
    bus_xfer(1'b0, 16'h00C0, '0, 0, '0, 1'b0);
    check("same_cycle_next", si_rdata, 32'hC0C0C0C0);

    // Upstream abandons during FWD: downstream completes, no upstream ack.
    si_cyc = 1; si_stb = 1; si_we = 0; si_addr = 16'h0100;
    @(posedge clk); #1;
    si_stb = 0; si_cyc = 0;
    check("drop_fwd_stb", {31'b0, mi_stb}, 32'd1);
    @(posedge clk); #1;
    check("drop_cyc_held", {31'b0, mi_cyc}, 32'd1);
    mi_ack = 1'b1; mi_rdata = 32'h77777777;
    @(posedge clk); #1;
    mi_ack = 1'b0;
    check("drop_no_ack", {31'b0, si_ack}, 32'd0);
    check("drop_mi_done", {30'b0, mi_cyc, mi_stb}, 32'd0);
    @(posedge clk); #1;
    check("drop_no_ack2", {31'b0, si_ack}, 32'd0);
    bus_xfer(1'b0, 16'h0104, '0, 0, 32'h31415926, 1'b0);

    // Randomized traffic mixed with table updates.
    pool[0] = 16'h0040; pool[1] = 16'h0080; pool[2] = 16'h00C0; pool[3] = 16'h0044;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        pool[4] = 16'($urandom);
        ctl_write(2'($urandom), pool[$urandom_range(0, 4)], $urandom, 1'($urandom_range(0, 3) != 0));
      end
      ra = pool[$urandom_range(0, 3)];
      bus_xfer(1'($urandom_range(0, 3) == 0), ra, $urandom, $urandom_range(0, 3), $urandom, 1'b0);
    end

    // Reset while a forwarded cycle is outstanding.
    si_cyc = 1; si_stb = 1; si_we = 0; si_addr = 16'h0200;
    @(posedge clk); #1;
    si_stb = 0;
    check("rstfwd_stb", {31'b0, mi_stb}, 32'd1);
    rst = 1'b1; si_cyc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("rstfwd_mi", {30'b0, mi_cyc, mi_stb}, 32'd0);
    check("rstfwd_hits", {16'b0, hit_count}, 32'd0);
    check("rstfwd_data", si_rdata, 32'd0);
    bus_xfer(1'b0, 16'h0040, '0, 0, 32'h0000CAFE, 1'b0);
    bus_xfer(1'b0, 16'h00C0, '0, 0, 32'h0000BEEF, 1'b0);

    // Saturation of the hit counter.
    ctl_write(2'd0, 16'h0300, 32'h00030003, 1'b1);
    for (int k = 0; k < int'(TB_HIT_MAX) + 10; k++)
      bus_xfer(1'b0, 16'h0300, '0, 0, '0, 1'b0);
    check("hits_saturated", {16'b0, hit_count}, {16'b0, TB_HIT_MAX});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
